busca_instrucao: RTL and testbench
==================================

Name: busca_instrucao

Overview:
- Instruction-fetch stage directly downstream of the program counter in the multicycle CPU.
- Takes the PC value (estado_pc) when the control sequencer pulses inicia, and reads a word-addressed instruction memory of parameterized latency.
- Holds the fetched word in an instruction register and offers it to decode with a valid/ready handshake.
- Produces the registered next-PC value (prox_instrucao) that feeds back into the PC.

Parameters:
- MEM_WORDS, 64: instruction memory depth in 32-bit words; power of 2, range 4..1024.
- LAT, 2: memory read latency in cycles; range 1..4.
- RESET_PC, 32'h00000000: value of prox_instrucao after reset.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous reset, active-low; takes effect when reset=0 at a rising edge of clock.
- estado_pc  in  32  current PC value; sampled only when inicia is accepted.
- inicia  in  1  start-fetch pulse from the control sequencer.
- desvio  in  1  branch/jump taken.
- alvo_desvio  in  32  branch target address.
- prog_we  in  1  instruction-memory write enable (program load).
- prog_addr  in  log2(MEM_WORDS)  word address for program load.
- prog_data  in  32  word to write.
- instrucao  out  32  instruction register.
- instr_valida  out  1  instrucao holds a valid word for decode.
- instr_pronta  in  1  decode accepts the word.
- prox_instrucao  out  32  next-PC value to the PC.
- erro_alinhamento  out  1  the delivered word is a substituted NOP because of a bad PC.
- ocupado  out  1  FSM is not in OCIOSO.

Behaviour:
- Reset (reset=0 at an edge):
  - state=OCIOSO; instrucao=0, instr_valida=0, erro_alinhamento=0, prox_instrucao=RESET_PC, internal counter=0.
  - Memory contents are NOT cleared.
  - Reset applied mid-fetch aborts the fetch; no word is delivered.
- FSM states: OCIOSO, LEITURA, ENTREGA, ERRO. ocupado=1 in every state except OCIOSO.
- OCIOSO, on inicia=1:
  - pc_reg<=estado_pc.
  - If estado_pc[1:0]!=0 or estado_pc[31:2]>=MEM_WORDS: go to ERRO.
  - Otherwise: cnt<=LAT-1 and go to LEITURA.
- LEITURA:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: instrucao<=mem[pc_reg[31:2]], instr_valida<=1, go to ENTREGA.
  - Latency: for inicia sampled at edge N, instr_valida=1 after edge N+LAT.
- ERRO: instrucao<=32'h00000013 (NOP), erro_alinhamento<=1, instr_valida<=1, go to ENTREGA.
- ENTREGA:
  - instrucao and erro_alinhamento are held stable while instr_valida=1.
  - Handshake occurs when instr_valida=1 and instr_pronta=1 at an edge. On handshake: instr_valida<=0, erro_alinhamento<=0, state<=OCIOSO.
  - instrucao keeps its last value after the handshake.
- inicia while ocupado=1: ignored, not queued.
- prox_instrucao update, evaluated every edge outside reset, in priority order:
  1. If desvio=1: prox_instrucao<={alvo_desvio[31:2],2'b00}.
  2. Else, on a handshake: prox_instrucao<=pc_reg+4, modulo 2^32 (pc_reg=32'hFFFFFFFC gives 0).
  3. Else: hold.
  - desvio and a handshake in the same cycle: desvio wins.
- Program load:
  - prog_we=1 writes mem[prog_addr]<=prog_data at the edge, in any state.
  - If the write hits the address being read in the final LEITURA cycle (cnt==0), instrucao gets the OLD word (read-before-write).
- instr_pronta=1 outside ENTREGA has no effect.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> instrucao=0, instr_valida=0, ocupado=0, prox_instrucao=0.
- Basic fetch, LAT=2: load mem[3]=32'h00A00093; estado_pc=32'h0C; pulse inicia at edge N; instr_pronta=1 -> instr_valida=1 after edge N+2 with instrucao=32'h00A00093; after edge N+3: instr_valida=0, prox_instrucao=32'h10.
- Backpressure: same fetch with instr_pronta=0 for 5 cycles -> instrucao stable and instr_valida=1 throughout; extra inicia pulses ignored; assert instr_pronta=1 -> single handshake, prox_instrucao=32'h10.
- Bad PC: estado_pc=32'h0E, then estado_pc=32'h400 with MEM_WORDS=64 -> each delivers instrucao=32'h00000013 with erro_alinhamento=1; after handshake, prox_instrucao=32'h12 and 32'h404 respectively.
- Branch priority: desvio=1, alvo_desvio=32'h2B in the handshake cycle -> prox_instrucao=32'h28, not pc_reg+4.
- Reset mid-fetch and write collision: reset=0 during LEITURA -> OCIOSO, instr_valida never asserted. Separately, prog_we to mem[3] with data 32'hDEADBEEF in the cnt==0 cycle -> instrucao=old word; a refetch returns 32'hDEADBEEF.

Source files
------------

// File: rtl/busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module      : busca_instrucao
// Description : Instruction-fetch stage of the multicycle CPU. It takes the
//               PC when the control sequencer pulses inicia and reads a
//               word-addressed instruction memory whose read latency is set
//               by a parameter. The fetched word goes into an instruction
//               register and is offered to decode through a valid/ready
//               handshake. The stage also produces the registered next-PC
//               value that feeds back into the PC.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MEM_WORDS : instruction memory depth in 32-bit words (power of 2, 4..1024)
//   LAT       : memory read latency in cycles (1..4)
//   RESET_PC  : value of prox_instrucao after reset
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous reset, active-low
//   estado_pc        in   current PC, sampled when inicia is accepted
//   inicia           in   start-fetch pulse (ignored while ocupado)
//   desvio           in   branch/jump taken
//   alvo_desvio      in   branch target address
//   prog_we          in   instruction-memory write enable (program load)
//   prog_addr        in   word address for program load
//   prog_data        in   word to write
//   instrucao        out  instruction register
//   instr_valida     out  instrucao holds a valid word for decode
//   instr_pronta     in   decode accepts the word
//   prox_instrucao   out  next-PC value
//   erro_alinhamento out  delivered word is a substituted NOP (bad PC)
//   ocupado          out  fetch in progress (FSM not idle)
// ============================================================================
module busca_instrucao #(
  parameter int          MEM_WORDS = 64,
  parameter int          LAT       = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [31:0]                  estado_pc,
  input  logic                         inicia,
  input  logic                         desvio,
  input  logic [31:0]                  alvo_desvio,
  input  logic                         prog_we,
  input  logic [$clog2(MEM_WORDS)-1:0] prog_addr,
  input  logic [31:0]                  prog_data,
  output logic [31:0]                  instrucao,
  output logic                         instr_valida,
  input  logic                         instr_pronta,
  output logic [31:0]                  prox_instrucao,
  output logic                         erro_alinhamento,
  output logic                         ocupado
);

  localparam int          c_ADDR_W   = $clog2(MEM_WORDS);
  localparam int          c_CNT_W    = 2;
  localparam logic [1:0]  c_CNT_INIT = c_CNT_W'(LAT - 1);
  // addi x0, x0, 0 : delivered in place of a word that cannot be fetched
  localparam logic [31:0] c_NOP      = 32'h0000_0013;
  localparam logic [31:0] c_WORD_INC = 32'd4;
  localparam logic [31:0] c_ALIGN    = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    LEITURA = 2'd1,
    ENTREGA = 2'd2,
    ERRO    = 2'd3
  } estado_t;

  estado_t              r_estado;
  estado_t              w_prox_estado;

  logic [31:0]          r_mem [MEM_WORDS];
  logic [31:0]          r_pc;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [31:0]          r_instrucao;
  logic                 r_valida;
  logic                 r_erro;
  logic [31:0]          r_prox;

  logic                 w_endereco_invalido;
  logic                 w_handshake;
  logic                 w_leitura_fim;
  logic [c_ADDR_W-1:0]  w_indice;

  // --------------------------------------------------------------------------
  // Address checks and handshake
  // --------------------------------------------------------------------------
  // A PC is unusable if it is not word aligned or if its word index lies
  // beyond the memory; the latter is simply any set bit above the index.
  assign w_endereco_invalido = (estado_pc[1:0] != 2'b00) ||
                               (estado_pc[31:c_ADDR_W+2] != '0);

  assign w_handshake   = (r_estado == ENTREGA) && r_valida && instr_pronta;
  assign w_leitura_fim = (r_estado == LEITURA) && (r_cnt == '0);
  assign w_indice      = r_pc[c_ADDR_W+1:2];

  // --------------------------------------------------------------------------
  // Instruction memory
  // --------------------------------------------------------------------------
  // Not affected by reset so a loaded program survives a CPU reset. The read
  // in the final LEITURA cycle is a non-blocking sample of the array, so a
  // write to the same word in that cycle yields the old contents.
  always_ff @(posedge clock) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (inicia) begin
          w_prox_estado = w_endereco_invalido ? ERRO : LEITURA;
        end
      end
      LEITURA: begin
        if (r_cnt == '0) begin
          w_prox_estado = ENTREGA;
        end
      end
      ERRO: begin
        w_prox_estado = ENTREGA;
      end
      ENTREGA: begin
        if (w_handshake) begin
          w_prox_estado = OCIOSO;
        end
      end
      default: begin
        w_prox_estado = OCIOSO;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: PC capture, latency counter, instruction register, flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc        <= '0;
      r_cnt       <= '0;
      r_instrucao <= '0;
      r_valida    <= 1'b0;
      r_erro      <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          // inicia is only honoured here; while busy it is dropped
          if (inicia) begin
            r_pc  <= estado_pc;
            r_cnt <= c_CNT_INIT;
          end
        end
        LEITURA: begin
          if (w_leitura_fim) begin
            r_instrucao <= r_mem[w_indice];
            r_valida    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ERRO: begin
          r_instrucao <= c_NOP;
          r_erro      <= 1'b1;
          r_valida    <= 1'b1;
        end
        ENTREGA: begin
          // instrucao is left untouched so decode can still see the last word
          if (w_handshake) begin
            r_valida <= 1'b0;
            r_erro   <= 1'b0;
          end
        end
        default: begin
          r_valida <= 1'b0;
          r_erro   <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-PC register: a taken branch overrides the sequential increment,
  // even when it coincides with the handshake. The increment wraps mod 2^32.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_prox <= RESET_PC;
    end else if (desvio) begin
      r_prox <= alvo_desvio & c_ALIGN;
    end else if (w_handshake) begin
      r_prox <= r_pc + c_WORD_INC;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign instrucao        = r_instrucao;
  assign instr_valida     = r_valida;
  assign erro_alinhamento = r_erro;
  assign prox_instrucao   = r_prox;
  assign ocupado          = (r_estado != OCIOSO);

endmodule
`default_nettype wire

// File: tb/tb_busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module      : tb_busca_instrucao
// Description : Self-checking bench for busca_instrucao (MEM_WORDS=64, LAT=2).
//               A table of per-cycle input/expected-output records, followed
//               by hand-written backpressure and mid-fetch reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_busca_instrucao;

  localparam int MEM_WORDS = 64;
  localparam int LAT       = 2;
  localparam int AW        = $clog2(MEM_WORDS);

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   estado_pc;
  logic          inicia;
  logic          desvio;
  logic [31:0]   alvo_desvio;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic [31:0]   instrucao;
  logic          instr_valida;
  logic          instr_pronta;
  logic [31:0]   prox_instrucao;
  logic          erro_alinhamento;
  logic          ocupado;

  int n_vec  = 0;
  int n_fail = 0;

  busca_instrucao #(
    .MEM_WORDS (MEM_WORDS),
    .LAT       (LAT),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .estado_pc        (estado_pc),
    .inicia           (inicia),
    .desvio           (desvio),
    .alvo_desvio      (alvo_desvio),
    .prog_we          (prog_we),
    .prog_addr        (prog_addr),
    .prog_data        (prog_data),
    .instrucao        (instrucao),
    .instr_valida     (instr_valida),
    .instr_pronta     (instr_pronta),
    .prox_instrucao   (prox_instrucao),
    .erro_alinhamento (erro_alinhamento),
    .ocupado          (ocupado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          rst_n;
    logic          ini;
    logic [31:0]   pc;
    logic          dsv;
    logic [31:0]   alvo;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          pronta;
    logic [31:0]   e_instr;
    logic          e_val;
    logic [31:0]   e_prox;
    logic          e_erro;
    logic          e_ocup;
  } vec_t;

  vec_t tab [32];

  function automatic vec_t mk(
    input logic r, input logic ini, input logic [31:0] pc,
    input logic dsv, input logic [31:0] alvo,
    input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
    input logic pronta,
    input logic [31:0] ei, input logic ev, input logic [31:0] ep,
    input logic ee, input logic eo);
    vec_t v;
    v.rst_n = r;  v.ini = ini;  v.pc = pc;  v.dsv = dsv;  v.alvo = alvo;
    v.we = we;    v.addr = addr; v.data = data; v.pronta = pronta;
    v.e_instr = ei; v.e_val = ev; v.e_prox = ep; v.e_erro = ee; v.e_ocup = eo;
    return v;
  endfunction

  task automatic chk(input string nome, input logic [31:0] ei, input logic ev,
                     input logic [31:0] ep, input logic ee, input logic eo);
    n_vec++;
    if (instrucao !== ei || instr_valida !== ev || prox_instrucao !== ep ||
        erro_alinhamento !== ee || ocupado !== eo) begin
      n_fail++;
      $display("FAIL %s: got instr=%h val=%b prox=%h erro=%b ocup=%b, want instr=%h val=%b prox=%h erro=%b ocup=%b",
               nome, instrucao, instr_valida, prox_instrucao, erro_alinhamento, ocupado,
               ei, ev, ep, ee, eo);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] W_ADDI = 32'h00A0_0093;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  initial begin
    //            rst ini pc            dsv alvo          we addr data          rdy  instr      val prox          err ocp
    tab[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h0,     0, 32'h0,        0, 0);
    tab[1]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h0,     0, 32'h0,        0, 0);
    tab[2]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 3, W_ADDI,       0,  32'h0,     0, 32'h0,        0, 0);
    // basic fetch of pc=0x0C, decode always ready
    tab[3]  = mk(1, 1, 32'h0C,       0, 32'h0,        0, 0, 32'h0,        1,  32'h0,     0, 32'h0,        0, 1);
    tab[4]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1,  32'h0,     0, 32'h0,        0, 1);
    tab[5]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1,  W_ADDI,    1, 32'h0,        0, 1);
    tab[6]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1,  W_ADDI,    0, 32'h10,       0, 0);
    // misaligned PC 0x0E
    tab[7]  = mk(1, 1, 32'h0E,       0, 32'h0,        0, 0, 32'h0,        0,  W_ADDI,    0, 32'h10,       0, 1);
    tab[8]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  NOP,       1, 32'h10,       1, 1);
    tab[9]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  NOP,       1, 32'h10,       1, 1);
    tab[10] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1,  NOP,       0, 32'h12,       0, 0);
    // out-of-range PC 0x400 (word 256 >= 64)
    tab[11] = mk(1, 1, 32'h400,      0, 32'h0,        0, 0, 32'h0,        0,  NOP,       0, 32'h12,       0, 1);
    tab[12] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  NOP,       1, 32'h12,       1, 1);
    tab[13] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1,  NOP,       0, 32'h404,      0, 0);
    // branch coinciding with handshake
    tab[14] = mk(1, 1, 32'h0C,       0, 32'h0,        0, 0, 32'h0,        0,  NOP,       0, 32'h404,      0, 1);
    tab[15] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  NOP,       0, 32'h404,      0, 1);
    tab[16] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  W_ADDI,    1, 32'h404,      0, 1);
    tab[17] = mk(1, 0, 32'h0,        1, 32'h2B,       0, 0, 32'h0,        1,  W_ADDI,    0, 32'h28,       0, 0);
    // branch while idle
    tab[18] = mk(1, 0, 32'h0,        1, 32'h107,      0, 0, 32'h0,        0,  W_ADDI,    0, 32'h104,      0, 0);
    // write collision on word 5 during the cnt==0 cycle
    tab[19] = mk(1, 0, 32'h0,        0, 32'h0,        1, 5, 32'h11111111, 0,  W_ADDI,    0, 32'h104,      0, 0);
    tab[20] = mk(1, 1, 32'h14,       0, 32'h0,        0, 0, 32'h0,        0,  W_ADDI,    0, 32'h104,      0, 1);
    tab[21] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  W_ADDI,    0, 32'h104,      0, 1);
    tab[22] = mk(1, 0, 32'h0,        0, 32'h0,        1, 5, 32'hDEADBEEF, 0,  32'h11111111, 1, 32'h104,   0, 1);
    tab[23] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1,  32'h11111111, 0, 32'h18,    0, 0);
    tab[24] = mk(1, 1, 32'h14,       0, 32'h0,        0, 0, 32'h0,        0,  32'h11111111, 0, 32'h18,    0, 1);
    tab[25] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h11111111, 0, 32'h18,    0, 1);
    tab[26] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'hDEADBEEF, 1, 32'h18,    0, 1);
    tab[27] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1,  32'hDEADBEEF, 0, 32'h18,    0, 0);
    // PC 0xFFFFFFFC: out of range, and pc+4 wraps to 0
    tab[28] = mk(1, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 0, 32'h0,        0,  32'hDEADBEEF, 0, 32'h18,    0, 1);
    tab[29] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  NOP,       1, 32'h18,       1, 1);
    tab[30] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1,  NOP,       0, 32'h0,        0, 0);
    // instr_pronta while idle has no effect
    tab[31] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1,  NOP,       0, 32'h0,        0, 0);

    reset = 1'b0; inicia = 1'b0; estado_pc = '0; desvio = 1'b0; alvo_desvio = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; instr_pronta = 1'b0;

    for (int i = 0; i < 32; i++) begin
      reset        = tab[i].rst_n;
      inicia       = tab[i].ini;
      estado_pc    = tab[i].pc;
      desvio       = tab[i].dsv;
      alvo_desvio  = tab[i].alvo;
      prog_we      = tab[i].we;
      prog_addr    = tab[i].addr;
      prog_data    = tab[i].data;
      instr_pronta = tab[i].pronta;
      step();
      chk($sformatf("vec%0d", i), tab[i].e_instr, tab[i].e_val, tab[i].e_prox,
          tab[i].e_erro, tab[i].e_ocup);
    end

    // Backpressure: word held while decode stalls, extra inicia dropped
    reset = 1'b1; desvio = 1'b0; prog_we = 1'b0; instr_pronta = 1'b0;
    inicia = 1'b1; estado_pc = 32'h0C;
    step(); chk("bp_start", NOP, 0, 32'h0, 0, 1);
    inicia = 1'b0;
    step(); chk("bp_wait", NOP, 0, 32'h0, 0, 1);
    step(); chk("bp_valid", W_ADDI, 1, 32'h0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      inicia = 1'b1; estado_pc = 32'h20;
      step(); chk($sformatf("bp_hold%0d", k), W_ADDI, 1, 32'h0, 0, 1);
    end
    inicia = 1'b0; instr_pronta = 1'b1;
    step(); chk("bp_handshake", W_ADDI, 0, 32'h10, 0, 0);
    instr_pronta = 1'b0;
    step(); chk("bp_no_queue", W_ADDI, 0, 32'h10, 0, 0);

    // Reset in the middle of a fetch
    inicia = 1'b1; estado_pc = 32'h0C;
    step(); chk("rst_mid_start", W_ADDI, 0, 32'h10, 0, 1);
    inicia = 1'b0; reset = 1'b0;
    step(); chk("rst_mid_apply", 32'h0, 0, 32'h0, 0, 0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk($sformatf("rst_mid_idle%0d", k), 32'h0, 0, 32'h0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
